muldiv_ctrl: RTL and testbench

//  Execute-stage sequencer for HI/LO arithmetic (MULT, MULTU, DIV, DIVU), sitting beside the ALU.

---
 rtl/muldiv_ctrl_pkg.sv | 34 +++
 rtl/muldiv_ctrl_if.sv | 26 ++
 rtl/muldiv_ctrl_div_radix2.sv | 61 ++++++
 rtl/muldiv_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared constants for the HI/LO multiply/divide sequencer: the EX-stage
//   operation codes it responds to, the sequencer state encoding and small
//   sign-handling helpers used by both the divider and the multiplier paths.
package muldiv_ctrl_pkg;

  // Operation codes presented on alucontrol
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Sequencer state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_DIV  = 2'd1;
  localparam logic [1:0] MD_MUL  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  // Magnitude of a 32-bit operand; unsigned operations pass the raw value.
  // 0x8000_0000 maps to itself, which reads correctly as an unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Two's-complement negate when neg is set
  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
//   Request/response bundle between the EX stage and the HI/LO sequencer.
//   master : EX stage side (drives start/alucontrol/src_a/src_b/flush)
//   slave  : sequencer side (drives stall_o/busy_o/done_o/hi_o/lo_o)
interface muldiv_ctrl_if;
  logic        start;
  logic [7:0]  alucontrol;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start, alucontrol, src_a, src_b, flush,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start, alucontrol, src_a, src_b, flush,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl_div_radix2.sv
// div_radix2
//   Unsigned restoring divider datapath, one quotient bit per step.
//   A 64-bit partial remainder holds {remainder, dividend/quotient}; every
//   step shifts left and subtracts the divisor when it fits.
// Ports
//   clk, resetn        clock, async active-low reset
//   load_i             capture dividend/divisor magnitudes
//   step_i             perform one restoring step
//   abort_i            clear the datapath (flush)
//   dividend_i/divisor_i  32-bit unsigned operands
//   quot_o             current low half (dividend right after load)
//   quot_nxt_o/rem_nxt_o  quotient/remainder after the step being taken now
module div_radix2 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] quot_nxt_o,
  output logic [31:0] rem_nxt_o
);

  logic [63:0] part_r;
  logic [31:0] divisor_r;
  logic [63:0] part_nxt_s;
  logic [33:0] diff_s;

  // One restoring step; the shifted remainder is 33 bits wide, so compare on 34
  always_comb begin
    diff_s = {1'b0, part_r[63:31]} - {2'b00, divisor_r};
    if (!diff_s[33]) begin
      part_nxt_s = {diff_s[31:0], part_r[30:0], 1'b1};
    end else begin
      part_nxt_s = {part_r[62:0], 1'b0};
    end
  end

  // Partial remainder and divisor storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      part_r    <= 64'd0;
      divisor_r <= 32'd0;
    end else if (abort_i) begin
      part_r    <= 64'd0;
      divisor_r <= 32'd0;
    end else if (load_i) begin
      part_r    <= {32'd0, dividend_i};
      divisor_r <= divisor_i;
    end else if (step_i) begin
      part_r    <= part_nxt_s;
    end
  end

  assign quot_o     = part_r[31:0];
  assign quot_nxt_o = part_nxt_s[31:0];
  assign rem_nxt_o  = part_nxt_s[63:32];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   EX-stage sequencer for MULT/MULTU/DIV/DIVU writing HI/LO. Runs the
//   radix-2 divider for 32 cycles while stalling the pipeline, aborts on
//   flush, and pulses done_o for one cycle when {hi_o, lo_o} is valid.
// Configuration macro: MULDIV_MULT_ITER_EN
//   undefined : MULT/MULTU complete in IDLE (done_o same cycle, no stall,
//               hi_o/lo_o loaded at that edge)
//   defined   : MULT/MULTU run 32 stalled shift-add cycles like a divide
// Ports
//   clk, resetn  clock, async active-low reset
//   bus (slave)  start/alucontrol/src_a/src_b/flush in;
//                stall_o/busy_o/done_o/hi_o/lo_o out
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int CNT_W     = 6
) (
  input logic          clk,
  input logic          resetn,
  muldiv_ctrl_if.slave bus
);

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             is_div_s, is_mul_s, is_signed_s;
  logic             accept_div_s, accept_mul_s, last_iter_s;
  logic             q_neg_r, r_neg_r, div_zero_r;
  logic [31:0]      hi_r, lo_r;
  logic [31:0]      a_mag_s, b_mag_s;
  logic [31:0]      div_quot_s, div_quot_nxt_s, div_rem_nxt_s;
  logic             div_step_s;
  logic             stall_s, done_s;

  // Operation decode
  always_comb begin
    is_div_s    = 1'b0;
    is_mul_s    = 1'b0;
    is_signed_s = 1'b0;
    case (bus.alucontrol)
      EXE_MULT_OP:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
      EXE_MULTU_OP: begin is_mul_s = 1'b1; end
      EXE_DIV_OP:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
      EXE_DIVU_OP:  begin is_div_s = 1'b1; end
      default:      begin is_div_s = 1'b0; end
    endcase
  end

  assign a_mag_s      = mag32(bus.src_a, is_signed_s);
  assign b_mag_s      = mag32(bus.src_b, is_signed_s);
  // flush outranks start, so a flushed instruction is never accepted
  assign accept_div_s = (state_r == MD_IDLE) & bus.start & ~bus.flush & is_div_s;
  assign accept_mul_s = (state_r == MD_IDLE) & bus.start & ~bus.flush & is_mul_s;
  assign last_iter_s  = (cnt_r == CNT_W'(DIV_ITERS - 1));
  assign div_step_s   = (state_r == MD_DIV) & ~bus.flush;

  div_radix2 u_div (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (accept_div_s),
    .step_i     (div_step_s),
    .abort_i    (bus.flush),
    .dividend_i (a_mag_s),
    .divisor_i  (b_mag_s),
    .quot_o     (div_quot_s),
    .quot_nxt_o (div_quot_nxt_s),
    .rem_nxt_o  (div_rem_nxt_s)
  );

  // Next-state and iteration counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CNT_W{1'b0}};
    if (bus.flush) begin
      state_nxt_s = MD_IDLE;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (accept_div_s) begin
            state_nxt_s = MD_DIV;
`ifdef MULDIV_MULT_ITER_EN
          end else if (accept_mul_s) begin
            state_nxt_s = MD_MUL;
`endif
          end else begin
            state_nxt_s = MD_IDLE;
          end
        end
        MD_DIV: begin
          // A zero divisor skips the iterations entirely
          if (div_zero_r || last_iter_s) begin
            state_nxt_s = MD_DONE;
          end else begin
            state_nxt_s = MD_DIV;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end
`ifdef MULDIV_MULT_ITER_EN
        MD_MUL: begin
          if (last_iter_s) begin
            state_nxt_s = MD_DONE;
          end else begin
            state_nxt_s = MD_MUL;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end
`endif
        // start is ignored here: the same instruction is still sitting in EX
        MD_DONE: state_nxt_s = MD_IDLE;
        default: state_nxt_s = MD_IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= MD_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Sign fixup flags captured with the operands
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (accept_div_s || accept_mul_s) begin
      q_neg_r    <= is_signed_s & (bus.src_a[31] ^ bus.src_b[31]);
      r_neg_r    <= is_signed_s & bus.src_a[31];
      div_zero_r <= (bus.src_b == 32'd0);
    end
  end

`ifdef MULDIV_MULT_ITER_EN
  logic [31:0] mcand_r;
  logic [63:0] acc_r, acc_nxt_s;
  logic [32:0] sum_s;

  // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set
  always_comb begin
    sum_s     = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mcand_r} : 33'd0);
    acc_nxt_s = {sum_s, acc_r[31:1]};
  end

  // Multiplier accumulator; the low half starts as the multiplier and shifts out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_r <= 32'd0;
      acc_r   <= 64'd0;
    end else if (bus.flush) begin
      mcand_r <= 32'd0;
      acc_r   <= 64'd0;
    end else if (accept_mul_s) begin
      mcand_r <= a_mag_s;
      acc_r   <= {32'd0, b_mag_s};
    end else if (state_r == MD_MUL) begin
      acc_r   <= acc_nxt_s;
    end
  end
`else
  logic [63:0] prod_s;

  // Single-cycle product
  always_comb begin
    prod_s = 64'd0;
    if (is_signed_s) begin
      prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) * $signed({{32{bus.src_b[31]}}, bus.src_b});
    end else begin
      prod_s = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    end
  end
`endif

  // HI/LO result registers: loaded only on an unflushed completion, held otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (!bus.flush) begin
      if (state_r == MD_DIV && div_zero_r) begin
        // Re-applying the dividend sign to its magnitude returns src_a unchanged
        hi_r <= neg_if32(div_quot_s, r_neg_r);
        lo_r <= 32'hFFFF_FFFF;
      end else if (state_r == MD_DIV && last_iter_s) begin
        hi_r <= neg_if32(div_rem_nxt_s, r_neg_r);
        lo_r <= neg_if32(div_quot_nxt_s, q_neg_r);
`ifdef MULDIV_MULT_ITER_EN
      end else if (state_r == MD_MUL && last_iter_s) begin
        {hi_r, lo_r} <= neg_if64(acc_nxt_s, q_neg_r);
`else
      end else if (accept_mul_s) begin
        {hi_r, lo_r} <= prod_s;
`endif
      end
    end
  end

  // Stall/done decode; gated by resetn so every output drops while reset is held
  always_comb begin
    stall_s = 1'b0;
    done_s  = 1'b0;
    if (!resetn) begin
      stall_s = 1'b0;
      done_s  = 1'b0;
    end else begin
`ifdef MULDIV_MULT_ITER_EN
      stall_s = accept_div_s | accept_mul_s | (state_r == MD_DIV) | (state_r == MD_MUL);
      done_s  = ~bus.flush & (state_r == MD_DONE);
`else
      stall_s = accept_div_s | (state_r == MD_DIV);
      done_s  = ~bus.flush & ((state_r == MD_DONE) | accept_mul_s);
`endif
    end
  end

  assign bus.stall_o = stall_s;
  assign bus.done_o  = done_s;
  assign bus.busy_o  = (state_r != MD_IDLE);
  assign bus.hi_o    = hi_r;
  assign bus.lo_o    = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Directed + randomized bench for muldiv_ctrl against an arithmetic
//   reference model (longint divide/multiply, plain latency rules).
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  logic [31:0] last_hi, last_lo;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    case (op)
      EXE_MULT_OP:  res = 64'(sa * sb);
      EXE_MULTU_OP: res = {32'd0, a} * {32'd0, b};
      EXE_DIV_OP: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      EXE_DIVU_OP: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Cycle (acceptance = 0) in which done_o is expected; also the stall count
  function automatic int ref_latency(input logic [7:0] op, input logic [31:0] b);
    if (op == EXE_DIV_OP || op == EXE_DIVU_OP) return (b == 32'd0) ? 2 : 33;
`ifdef MULDIV_MULT_ITER_EN
    return 33;
`else
    return 0;
`endif
  endfunction

  // Issue one instruction, hold start while stalled and through DONE, then check
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int exp_lat, done_cyc, stalls, pulses;
    exp      = ref_model(op, a, b);
    exp_lat  = ref_latency(op, b);
    done_cyc = -1;
    stalls   = 0;
    pulses   = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = op; bus.src_a = a; bus.src_b = b;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.stall_o) stalls++;
      if (bus.done_o) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
        if (exp_lat > 0) begin
          check_val("done_hi", {32'd0, bus.hi_o}, {32'd0, exp[63:32]});
          check_val("done_lo", {32'd0, bus.lo_o}, {32'd0, exp[31:0]});
        end
      end
      @(negedge clk);
      if (done_cyc >= 0 && c == done_cyc) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    #1;
    check_val("done_cycle", 64'(done_cyc), 64'(exp_lat));
    check_val("stall_cycles", 64'(stalls), 64'(exp_lat));
    check_val("done_pulses", 64'(pulses), 64'd1);
    check_val("result", {bus.hi_o, bus.lo_o}, exp);
    check_val("busy_idle", {63'd0, bus.busy_o}, 64'd0);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  // Flush a DIVU at busy cycle 10, then issue DIVU 9/3 immediately
  task automatic flush_test();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = EXE_DIVU_OP; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.done_o) pulses++;
      @(negedge clk);
    end
    bus.flush = 1'b1; bus.start = 1'b0;
    #1;
    check_val("flush_busy_before", {63'd0, bus.busy_o}, 64'd1);
    check_val("flush_done", {63'd0, bus.done_o}, 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check_val("flush_pulses", 64'(pulses), 64'd0);
    check_val("flush_busy_after", {63'd0, bus.busy_o}, 64'd0);
    check_val("flush_done_after", {63'd0, bus.done_o}, 64'd0);
    check_val("flush_hilo", {bus.hi_o, bus.lo_o}, {last_hi, last_lo});
    do_op(EXE_DIVU_OP, 32'd9, 32'd3);
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] a, b;
    int sel, r;
    n_checks = 0;
    n_errors = 0;
    last_hi  = 32'd0;
    last_lo  = 32'd0;
    resetn = 1'b1;
    bus.start = 1'b0; bus.alucontrol = 8'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.flush = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check_val("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    check_val("rst_busy",  {63'd0, bus.busy_o},  64'd0);
    check_val("rst_done",  {63'd0, bus.done_o},  64'd0);
    check_val("rst_hilo",  {bus.hi_o, bus.lo_o}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    do_op(EXE_DIVU_OP,  32'd100,        32'd7);
    do_op(EXE_DIV_OP,   32'hFFFF_FFF9,  32'd2);
    do_op(EXE_DIV_OP,   32'h8000_0000,  32'hFFFF_FFFF);
    do_op(EXE_DIV_OP,   32'd5,          32'd0);
    do_op(EXE_DIV_OP,   32'hFFFF_FFFB,  32'd0);
    do_op(EXE_DIVU_OP,  32'hFFFF_FFFF,  32'd1);
    do_op(EXE_MULT_OP,  32'hFFFF_FFFE,  32'd3);
    do_op(EXE_MULTU_OP, 32'hFFFF_FFFF,  32'd2);

    // Non-mul/div operation with start is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = 8'h20; bus.src_a = 32'd12; bus.src_b = 32'd4;
    #1;
    check_val("nop_stall", {63'd0, bus.stall_o}, 64'd0);
    check_val("nop_done",  {63'd0, bus.done_o},  64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check_val("nop_busy", {63'd0, bus.busy_o}, 64'd0);
    check_val("nop_hilo", {bus.hi_o, bus.lo_o}, {last_hi, last_lo});

    flush_test();

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       op = EXE_MULT_OP;
        1:       op = EXE_MULTU_OP;
        2:       op = EXE_DIV_OP;
        default: op = EXE_DIVU_OP;
      endcase
      a = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0)      b = 32'd0;
      else if (r == 1) b = 32'($urandom_range(1, 15));
      else             b = $urandom;
      do_op(op, a, b);
    end

    // Reset mid-divide with start still high
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = EXE_DIV_OP; bus.src_a = 32'd77; bus.src_b = 32'd5;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_val("midrst_stall", {63'd0, bus.stall_o}, 64'd0);
    check_val("midrst_busy",  {63'd0, bus.busy_o},  64'd0);
    check_val("midrst_done",  {63'd0, bus.done_o},  64'd0);
    check_val("midrst_hilo",  {bus.hi_o, bus.lo_o}, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;
    do_op(EXE_DIVU_OP, 32'd9, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
